// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus controller.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int DEPTH_DEFAULT = 128;
  localparam int WORD_SHIFT    = 2;

endpackage

// File: rtl/bus_tristate_drv.sv
// Tri-state driver for the shared Mem_Bus: drives data when enabled, Z otherwise.
module bus_tristate_drv #(
  parameter int DATA_W = 32
) (
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  inout  wire  [DATA_W-1:0] bus
);

  assign bus = en ? data : 'z;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-word bus master in front of the negedge RAM: request handshake,
// CS/WE/ADDR strobes, write-side bus drive and fixed-latency response.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              CS,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Mem_Bus
);

  state_e              state_q, state_d;
  logic                cs_q, cs_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                accept;
  logic                drv_en;

  // Misaligned or beyond the last RAM word; the word index never wraps.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[WORD_SHIFT-1:0] != '0) || ((a >> WORD_SHIFT) >= ADDR_W'(DEPTH));
  endfunction

  assign req_ready = (state_q != ACCESS);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    cs_d        = 1'b0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          if (addr_bad(req_addr)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            cs_d    = 1'b1;
            we_d    = req_we;
            addr_d  = req_addr >> WORD_SHIFT;
            wdata_d = req_wdata;
          end
        end
      end
      ACCESS: begin
        // The RAM has driven read data since the falling edge of this cycle.
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? '0 : Mem_Bus;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Write data is only observed while CS/WE qualify it, so it needs no reset.
  always_ff @(posedge CLK) begin
    wdata_q <= wdata_d;
  end

  assign CS        = cs_q;
  assign WE        = we_q;
  assign ADDR      = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign drv_en = (state_q == ACCESS) && we_q;

  bus_tristate_drv #(
    .DATA_W(DATA_W)
  ) u_drv (
    .en   (drv_en),
    .data (wdata_q),
    .bus  (Mem_Bus)
  );

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl with a negedge RAM model on Mem_Bus.
module tb_mem_bus_ctrl;

  localparam int DEPTH = 128;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        CS;
  logic        WE;
  logic [31:0] ADDR;
  wire  [31:0] Mem_Bus;

  mem_bus_ctrl #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .CS        (CS),
    .WE        (WE),
    .ADDR      (ADDR),
    .Mem_Bus   (Mem_Bus)
  );

  always #5 CLK = ~CLK;

  // RAM model: negedge clocked, drives the bus whenever selected for a read.
  logic [31:0] ram [DEPTH];
  logic [31:0] ram_dout = '0;
  wire         ram_oe = CS && !WE;
  assign Mem_Bus = ram_oe ? ram_dout : 'z;

  always @(negedge CLK) begin
    if (CS && WE && ADDR < DEPTH) ram[ADDR[6:0]] <= Mem_Bus;
    if (CS && !WE && ADDR < DEPTH) ram_dout <= ram[ADDR[6:0]];
  end

  // Reference model: word-addressed memory image and the access rules.
  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    int          due;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cs_t;

  rsp_t rsp_q [$];
  cs_t  cs_q  [$];
  rsp_t re;
  cs_t  ce;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int violations = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request, wait (bounded) for the handshake, record expectations.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output int acc);
    int   waited = 0;
    int   word;
    logic bad;
    rsp_t r;
    cs_t  c;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    acc       = -1;
    @(negedge CLK);
    while (!req_ready && waited < 10) begin
      waited++;
      @(negedge CLK);
    end
    check("accept_ready", {63'd0, req_ready}, 64'd1);
    if (req_ready) begin
      acc  = cyc + 1;
      word = int'(addr >> 2);
      bad  = (addr % 4 != 0) || (addr / 4 >= DEPTH);
      if (bad) begin
        r.due = cyc + 1; r.rdata = '0; r.err = 1'b1;
        rsp_q.push_back(r);
      end else begin
        c.due = cyc + 1; c.we = we; c.addr = addr / 4; c.wdata = wd;
        cs_q.push_back(c);
        r.due = cyc + 2; r.err = 1'b0;
        r.rdata = we ? 32'd0 : ref_mem[word];
        if (we) ref_mem[word] = wd;
        rsp_q.push_back(r);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compares every strobe and response against the scoreboard.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (CS) begin
        if (cs_q.size() == 0) check("cs_unexpected_qsize", 64'(cs_q.size()), 64'd1);
        else begin
          ce = cs_q.pop_front();
          check("cs_cycle", 64'(cyc), 64'(ce.due));
          check("cs_we", {63'd0, WE}, {63'd0, ce.we});
          check("cs_addr", {32'd0, ADDR}, {32'd0, ce.addr});
          if (ce.we) check("bus_wdata", {32'd0, Mem_Bus}, {32'd0, ce.wdata});
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) check("rsp_unexpected_qsize", 64'(rsp_q.size()), 64'd1);
        else begin
          re = rsp_q.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(re.due));
          check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, re.rdata});
          check("rsp_err", {63'd0, rsp_err}, {63'd0, re.err});
        end
      end
      if (cs_q.size() > 0 && cs_q[0].due < cyc) begin
        check("cs_timeout", 64'(cyc), 64'(cs_q[0].due));
        void'(cs_q.pop_front());
      end
      if (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
        check("rsp_timeout", 64'(cyc), 64'(rsp_q[0].due));
        void'(rsp_q.pop_front());
      end
    end
    if (dut.drv_en && !(CS && WE)) violations++;
    if (CS && $isunknown(Mem_Bus)) violations++;
  end

  initial begin
    int a0, a1, a2, acc;
    int sel;
    logic [31:0] addr;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end

    repeat (3) @(negedge CLK);
    check("rst_cs", {63'd0, CS}, 64'd0);
    check("rst_we", {63'd0, WE}, 64'd0);
    check("rst_addr", {32'd0, ADDR}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Write then read back a single word.
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, acc);
    issue(1'b0, 32'h10, 32'h0, acc);
    req_valid = 1'b0;
    repeat (3) @(posedge CLK); #1;
    check("ram_word4", {32'd0, ram[4]}, {32'd0, 32'hDEAD_BEEF});

    // Misaligned and range boundaries.
    issue(1'b0, 32'h13, 32'h0, acc);
    issue(1'b0, 32'h1FC, 32'h0, acc);
    issue(1'b0, 32'h200, 32'h0, acc);
    issue(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, acc);
    req_valid = 1'b0;
    repeat (3) @(posedge CLK); #1;

    // Back-to-back writes with req_valid held high.
    issue(1'b1, 32'h0, 32'h1111_0000, a0);
    issue(1'b1, 32'h4, 32'h2222_0001, a1);
    issue(1'b1, 32'h8, 32'h3333_0002, a2);
    req_valid = 1'b0;
    repeat (3) @(posedge CLK); #1;
    check("b2b_gap01", 64'(a1 - a0), 64'd2);
    check("b2b_gap12", 64'(a2 - a1), 64'd2);
    check("ram_word0", {32'd0, ram[0]}, {32'd0, 32'h1111_0000});
    check("ram_word1", {32'd0, ram[1]}, {32'd0, 32'h2222_0001});
    check("ram_word2", {32'd0, ram[2]}, {32'd0, 32'h3333_0002});

    // Random mixed stream.
    for (int n = 0; n < 200; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)
        addr = ({25'd0, 7'($urandom_range(0, DEPTH - 1))} << 2) | 32'($urandom_range(1, 3));
      else if (sel == 1)
        addr = 32'h200 + (32'($urandom_range(0, 4095)) << 2);
      else
        addr = {25'd0, 7'($urandom_range(0, DEPTH - 1))} << 2;
      issue(1'($urandom_range(0, 1)), addr, $urandom, acc);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        @(posedge CLK); #1;
      end
    end
    req_valid = 1'b0;
    repeat (4) @(posedge CLK); #1;

    // Reset in the middle of a read access.
    issue(1'b0, 32'h40, 32'h0, acc);
    req_valid = 1'b0;
    #1;
    RST_N = 1'b0;
    rsp_q.delete();
    cs_q.delete();
    #1;
    check("midrst_cs", {63'd0, CS}, 64'd0);
    check("midrst_we", {63'd0, WE}, 64'd0);
    check("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("midrst_drv_en", {63'd0, dut.drv_en}, 64'd0);
    check("midrst_addr", {32'd0, ADDR}, 64'd0);
    @(negedge CLK);
    @(posedge CLK); #2;
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("postrst_ready", {63'd0, req_ready}, 64'd1);
      check("postrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("postrst_cs", {63'd0, CS}, 64'd0);
    end

    // One more transaction after reset to confirm normal operation.
    @(posedge CLK); #1;
    issue(1'b0, 32'h10, 32'h0, acc);
    req_valid = 1'b0;
    repeat (4) @(posedge CLK); #1;

    check("drain_rsp_q", 64'(rsp_q.size()), 64'd0);
    check("drain_cs_q", 64'(cs_q.size()), 64'd0);
    check("bus_contention", 64'(violations), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=<200000", $time);
    $fatal(1, "timeout");
  end

endmodule
